axi_st_pkt_fifo: RTL and testbench

Parametrised AXI Stream FIFO with full sideband carriage (tdata, tstrb, tkeep, tlast, tid, tdest, tuser), configurable depth, and an optional packet (store-and-forward) mode. It sits between an upstream `axi_st_if.master` and a downstream `axi_st_if.slave` to decouple back-pressure, absorb bursts and, in packet mode, guarantee that downstream never sees a partial packet stall mid-stream.

---
 rtl/axi_st_pkg.sv | 24 ++
 rtl/axi_st_if.sv | 40 ++++
 rtl/axi_st_fifo_mem.sv | 36 +++
 rtl/axi_st_pkt_fifo.sv | 137 +++++++++++++
 tb/tb_axi_st_pkt_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_st_pkg.sv
// AXI Stream shared widths and the packed FIFO word width helper.
// Imported by the stream interface, the FIFO top and its storage.
package axi_st_pkg;

  localparam int SYMBOL_W   = 8;
  localparam int SYMBOL_NUM = 16;
  localparam int DATA_W     = SYMBOL_W * SYMBOL_NUM;
  localparam int TID_W      = 8;
  localparam int TDEST_W    = 8;
  localparam int TUSER_W    = 8;

  // {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}
  function automatic int axi_st_word_w(
    input int data_w,
    input int sym_num,
    input int tid_w,
    input int tdest_w,
    input int tuser_w
  );
    return data_w + 2 * sym_num + 1
         + tid_w + tdest_w + tuser_w;
  endfunction

endpackage

// File: rtl/axi_st_if.sv
// Stream bundle (master drives payload/tvalid, slave drives tready)
// and the clock/reset bundle consumed through its sink modport.
interface axi_st_if
  import axi_st_pkg::*;
#(
  parameter int DATA_W     = axi_st_pkg::DATA_W,
  parameter int SYMBOL_NUM = axi_st_pkg::SYMBOL_NUM,
  parameter int TID_W      = axi_st_pkg::TID_W,
  parameter int TDEST_W    = axi_st_pkg::TDEST_W,
  parameter int TUSER_W    = axi_st_pkg::TUSER_W
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [SYMBOL_NUM-1:0] tstrb;
  logic [SYMBOL_NUM-1:0] tkeep;
  logic                  tlast;
  logic [TID_W-1:0]      tid;
  logic [TDEST_W-1:0]    tdest;
  logic [TUSER_W-1:0]    tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tlast, tid, tdest, tuser,
    output tready
  );
endinterface

interface clk_rst_if ();
  logic clk;
  logic rst;

  modport sink (input clk, input rst);
endinterface

// File: rtl/axi_st_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Ports: clk_i, rst_i (read register only), we/waddr/wdata, raddr/rdata.
module axi_st_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reset only the read register so the port shows zeros in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_st_pkt_fifo.sv
// AXI Stream FIFO with full sideband and optional store-and-forward.
// Ports: clk_rst (sink), s_axis (slave), m_axis (master), count, pkt_count.
module axi_st_pkt_fifo
  import axi_st_pkg::*;
#(
  parameter int SYMBOL_W   = axi_st_pkg::SYMBOL_W,
  parameter int SYMBOL_NUM = axi_st_pkg::SYMBOL_NUM,
  parameter int DATA_W     = axi_st_pkg::DATA_W,
  parameter int TID_W      = axi_st_pkg::TID_W,
  parameter int TDEST_W    = axi_st_pkg::TDEST_W,
  parameter int TUSER_W    = axi_st_pkg::TUSER_W,
  parameter int DEPTH      = 16,
  parameter bit PKT_MODE   = 1'b0
) (
  clk_rst_if.sink                     clk_rst,
  axi_st_if.slave                     s_axis,
  axi_st_if.master                    m_axis,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = axi_st_word_w(
    DATA_W, SYMBOL_NUM, TID_W, TDEST_W, TUSER_W);

  if (DATA_W != SYMBOL_W * SYMBOL_NUM) begin : g_bad_data_w
    $error("DATA_W must equal SYMBOL_W*SYMBOL_NUM");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic          clk;
  logic          rst;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic [CW-1:0] pkt_old;
  logic [PW-1:0] avail;
  logic          m_tvalid_q, m_tvalid_d;
  logic          full;
  logic          wr_en;
  logic          rd_en;
  logic [WW-1:0] wdata;
  logic [WW-1:0] rdata;

  assign clk = clk_rst.clk;
  assign rst = clk_rst.rst;

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW])
             && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign s_axis.tready = !full && !rst;
  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = m_tvalid_q && m_axis.tready;

  assign wdata = {s_axis.tdata, s_axis.tstrb,
                  s_axis.tkeep, s_axis.tlast,
                  s_axis.tid, s_axis.tdest,
                  s_axis.tuser};

  assign {m_axis.tdata, m_axis.tstrb,
          m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest,
          m_axis.tuser} = rdata;

  assign m_axis.tvalid = m_tvalid_q;
  assign count         = count_q;
  assign pkt_count     = pkt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);

    unique case (1'b1)
      wr_en && !rd_en: count_d = count_q + CW'(1);
      rd_en && !wr_en: count_d = count_q - CW'(1);
      default:         count_d = count_q;
    endcase

    pkt_d = pkt_q;
    if (PKT_MODE) begin
      unique case (1'b1)
        (wr_en && s_axis.tlast)
          && !(rd_en && m_axis.tlast):
          pkt_d = pkt_q + CW'(1);
        (rd_en && m_axis.tlast)
          && !(wr_en && s_axis.tlast):
          pkt_d = pkt_q - CW'(1);
        default: pkt_d = pkt_q;
      endcase
    end

    // The output register is refilled from mem[rd_ptr_d] on this
    // edge, so only beats written before this edge are presentable.
    avail   = wr_ptr_q - rd_ptr_d;
    pkt_old = pkt_q - CW'(rd_en && m_axis.tlast);

    // avail[AW] set means the FIFO is full: oversized packets are
    // released cut-through so the writer can never deadlock.
    m_tvalid_d = (avail != '0)
              && (!PKT_MODE || pkt_old != '0 || avail[AW]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_q      <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_q      <= pkt_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  axi_st_fifo_mem #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_axi_st_pkt_fifo.sv
// Random/directed bench for axi_st_pkt_fifo on three configurations
// against a queue-based reference of the FIFO's visible behaviour.
module tb_axi_st_pkt_fifo;

  localparam int N  = 3;
  localparam int DW = 128;
  localparam int SN = 16;
  localparam int IW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SN-1:0] strb;
    logic [SN-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [IW-1:0] dest;
    logic [IW-1:0] user;
  } beat_t;

  clk_rst_if cr ();

  axi_st_if #(.DATA_W(DW), .SYMBOL_NUM(SN), .TID_W(IW),
    .TDEST_W(IW), .TUSER_W(IW)) s0 (), s1 (), s2 ();
  axi_st_if #(.DATA_W(DW), .SYMBOL_NUM(SN), .TID_W(IW),
    .TDEST_W(IW), .TUSER_W(IW)) m0 (), m1 (), m2 ();

  logic  sv [N];
  beat_t sb [N];
  logic  mr [N];
  logic  sr [N];
  logic  mv [N];
  beat_t mb [N];
  int    cnt [N];
  int    pc [N];

  logic [2:0] c0, p0, c2, p2;
  logic [4:0] c1, p1;

  assign s0.tvalid = sv[0];
  assign s1.tvalid = sv[1];
  assign s2.tvalid = sv[2];
  assign {s0.tdata, s0.tstrb, s0.tkeep, s0.tlast,
          s0.tid, s0.tdest, s0.tuser} = sb[0];
  assign {s1.tdata, s1.tstrb, s1.tkeep, s1.tlast,
          s1.tid, s1.tdest, s1.tuser} = sb[1];
  assign {s2.tdata, s2.tstrb, s2.tkeep, s2.tlast,
          s2.tid, s2.tdest, s2.tuser} = sb[2];
  assign m0.tready = mr[0];
  assign m1.tready = mr[1];
  assign m2.tready = mr[2];
  assign sr[0] = s0.tready;
  assign sr[1] = s1.tready;
  assign sr[2] = s2.tready;
  assign mv[0] = m0.tvalid;
  assign mv[1] = m1.tvalid;
  assign mv[2] = m2.tvalid;
  assign mb[0] = {m0.tdata, m0.tstrb, m0.tkeep, m0.tlast,
                  m0.tid, m0.tdest, m0.tuser};
  assign mb[1] = {m1.tdata, m1.tstrb, m1.tkeep, m1.tlast,
                  m1.tid, m1.tdest, m1.tuser};
  assign mb[2] = {m2.tdata, m2.tstrb, m2.tkeep, m2.tlast,
                  m2.tid, m2.tdest, m2.tuser};
  assign cnt[0] = int'(c0);
  assign cnt[1] = int'(c1);
  assign cnt[2] = int'(c2);
  assign pc[0]  = int'(p0);
  assign pc[1]  = int'(p1);
  assign pc[2]  = int'(p2);

  axi_st_pkt_fifo #(.SYMBOL_W(8), .SYMBOL_NUM(SN), .DATA_W(DW),
    .TID_W(IW), .TDEST_W(IW), .TUSER_W(IW),
    .DEPTH(4), .PKT_MODE(1'b0)) u_dut0 (
    .clk_rst(cr), .s_axis(s0), .m_axis(m0),
    .count(c0), .pkt_count(p0));

  axi_st_pkt_fifo #(.SYMBOL_W(8), .SYMBOL_NUM(SN), .DATA_W(DW),
    .TID_W(IW), .TDEST_W(IW), .TUSER_W(IW),
    .DEPTH(16), .PKT_MODE(1'b1)) u_dut1 (
    .clk_rst(cr), .s_axis(s1), .m_axis(m1),
    .count(c1), .pkt_count(p1));

  axi_st_pkt_fifo #(.SYMBOL_W(8), .SYMBOL_NUM(SN), .DATA_W(DW),
    .TID_W(IW), .TDEST_W(IW), .TUSER_W(IW),
    .DEPTH(4), .PKT_MODE(1'b1)) u_dut2 (
    .clk_rst(cr), .s_axis(s2), .m_axis(m2),
    .count(c2), .pkt_count(p2));

  always #5 cr.clk = ~cr.clk;

  beat_t q [N][$];
  int    st [N][$];
  int    cyc;
  int    n_chk;
  int    n_pass;
  int    seq [N];
  int    bidx [N];
  int    plen [N];
  int    len_cfg [N];
  int    budget [N];
  int    sv_mode [N];
  int    mr_mode [N];

  function automatic int dep_of(input int k);
    return (k == 1) ? 16 : 4;
  endfunction

  function automatic bit pkt_of(input int k);
    return k != 0;
  endfunction

  // A beat is presentable one cycle after it is written; in packet
  // mode a complete packet or a full store must be presentable.
  function automatic bit exp_valid(input int k);
    int old = 0;
    int lasts = 0;
    for (int i = 0; i < q[k].size(); i++) begin
      if (st[k][i] < cyc) begin
        old++;
        if (q[k][i].last) lasts++;
      end
    end
    if (old == 0) return 1'b0;
    return !pkt_of(k) || lasts != 0 || old == dep_of(k);
  endfunction

  function automatic int exp_pkts(input int k);
    int n = 0;
    if (!pkt_of(k)) return 0;
    for (int i = 0; i < q[k].size(); i++)
      if (q[k][i].last) n++;
    return n;
  endfunction

  function automatic beat_t mk_beat(input int k);
    beat_t b;
    if (bidx[k] == 0)
      plen[k] = (len_cfg[k] != 0) ? len_cfg[k]
                                  : int'($urandom_range(1, 6));
    b.data = {$urandom, $urandom, $urandom, seq[k]};
    seq[k]++;
    b.strb = SN'($urandom);
    b.keep = SN'($urandom);
    b.id   = IW'($urandom);
    b.dest = IW'($urandom);
    b.user = IW'($urandom);
    b.last = (bidx[k] == plen[k] - 1);
    return b;
  endfunction

  function automatic bit src_want(input int k);
    if (budget[k] <= 0) return 1'b0;
    if (sv_mode[k] == 1) return 1'b1;
    return sv_mode[k] == 2 && $urandom_range(0, 1) == 1;
  endfunction

  task automatic check(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    bit ev;
    for (int k = 0; k < N; k++) begin
      ev = !cr.rst && exp_valid(k);
      check($sformatf("m_tvalid%0d", k), 256'(mv[k]), 256'(ev));
      check($sformatf("s_tready%0d", k), 256'(sr[k]),
        256'(!cr.rst && q[k].size() < dep_of(k)));
      check($sformatf("count%0d", k), 256'(cnt[k]),
        256'(q[k].size()));
      check($sformatf("pkt_count%0d", k), 256'(pc[k]),
        256'(exp_pkts(k)));
      if (cr.rst)
        check($sformatf("rst_payload%0d", k), 256'(mb[k]), '0);
      else if (ev)
        check($sformatf("payload%0d", k), 256'(mb[k]),
          256'(q[k][0]));
    end
  endtask

  task automatic step();
    bit wr [N];
    bit rd [N];
    for (int k = 0; k < N; k++) begin
      if (!sv[k]) sv[k] = src_want(k);
      mr[k] = (mr_mode[k] == 1)
           || (mr_mode[k] == 2 && $urandom_range(0, 1) == 1);
      wr[k] = !cr.rst && sv[k] && q[k].size() < dep_of(k);
      rd[k] = !cr.rst && exp_valid(k) && mr[k];
    end
    @(posedge cr.clk);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (rd[k]) begin
        void'(q[k].pop_front());
        void'(st[k].pop_front());
      end
      if (wr[k]) begin
        q[k].push_back(sb[k]);
        st[k].push_back(cyc);
      end
    end
    @(negedge cr.clk);
    check_all();
    for (int k = 0; k < N; k++) begin
      if (wr[k]) begin
        budget[k]--;
        bidx[k] = sb[k].last ? 0 : bidx[k] + 1;
        sv[k] = 1'b0;
        sb[k] = mk_beat(k);
      end
    end
  endtask

  // Asynchronous reset: outputs are checked before any clock edge.
  task automatic do_reset();
    cr.rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      st[k].delete();
      bidx[k] = 0;
      sv[k] = 1'b0;
      mr[k] = 1'b0;
      budget[k] = 0;
      sv_mode[k] = 0;
      mr_mode[k] = 0;
      sb[k] = mk_beat(k);
    end
    check_all();
    repeat (2) step();
    cr.rst = 1'b0;
    step();
  endtask

  initial begin
    cr.clk = 1'b0;
    cr.rst = 1'b0;
    cyc = 0;
    n_chk = 0;
    n_pass = 0;
    for (int k = 0; k < N; k++) begin
      seq[k] = 1;
      bidx[k] = 0;
      plen[k] = 1;
      len_cfg[k] = 0;
      budget[k] = 0;
      sv_mode[k] = 0;
      mr_mode[k] = 0;
      sv[k] = 1'b0;
      mr[k] = 1'b0;
      sb[k] = '0;
    end
    #2;
    do_reset();

    budget[0] = 4;
    sv_mode[0] = 1;
    repeat (6) step();
    mr_mode[0] = 1;
    repeat (6) step();

    do_reset();
    for (int k = 0; k < N; k++) begin
      budget[k] = 100;
      sv_mode[k] = 1;
      mr_mode[k] = 1;
    end
    repeat (110) step();
    repeat (12) step();

    len_cfg[1] = 3;
    do_reset();
    budget[1] = 3;
    sv_mode[1] = 1;
    mr_mode[1] = 1;
    repeat (8) step();

    len_cfg[2] = 6;
    do_reset();
    budget[2] = 6;
    sv_mode[2] = 1;
    mr_mode[2] = 1;
    repeat (30) step();

    for (int k = 0; k < N; k++) len_cfg[k] = 5;
    do_reset();
    for (int k = 0; k < N; k++) begin
      budget[k] = 3;
      sv_mode[k] = 1;
    end
    repeat (5) step();
    for (int k = 0; k < N; k++) len_cfg[k] = 2;
    do_reset();
    for (int k = 0; k < N; k++) begin
      budget[k] = 2;
      sv_mode[k] = 1;
      mr_mode[k] = 1;
    end
    repeat (8) step();

    for (int k = 0; k < N; k++) len_cfg[k] = 0;
    do_reset();
    for (int k = 0; k < N; k++) begin
      budget[k] = 1000;
      sv_mode[k] = 2;
      mr_mode[k] = 2;
    end
    repeat (400) step();
    for (int k = 0; k < N; k++) begin
      budget[k] = 0;
      mr_mode[k] = 1;
    end
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
